// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, 11-bit frame, ACK check.
// Optional resend-once on error when PS2_TX_RETRY_EN is defined.
//
// Ports:
//   CLK100MHZ, CPU_RESETN         system clock, async active-low reset
//   tx_data, tx_valid, tx_ready   command byte handshake (accept in IDLE)
//   busy, done, ack_err,
//   timeout_err                   status; done/errors are one-cycle pulses
//   ps2_clk_i, ps2_data_i         raw pin levels (async)
//   ps2_clk_low, ps2_data_low     registered open-drain pull-down enables
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 12000,
    parameter int unsigned SETUP_CYCLES   = 200,
    parameter int unsigned TIMEOUT_CYCLES = 2000000,
    parameter int unsigned FILTER_LEN     = 8
) (
    input  logic       CLK100MHZ,
    input  logic       CPU_RESETN,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic       timeout_err,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       ps2_clk_low,
    output logic       ps2_data_low
);

    localparam int unsigned TMR_MAX =
        (INHIBIT_CYCLES > SETUP_CYCLES) ? INHIBIT_CYCLES : SETUP_CYCLES;
    localparam int TMR_W = $clog2(TMR_MAX + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int FLT_W = $clog2(FILTER_LEN + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_REQ,
        S_XFER,
        S_ACK,
        S_WAIT_IDLE
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] byte_q, byte_d;
    logic [3:0] bit_q, bit_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [1:0] clk_s_q, clk_s_d;
    logic [1:0] dat_s_q, dat_s_d;
    logic       filt_q, filt_d;
    logic [FLT_W-1:0] fcnt_q, fcnt_d;
    logic       clk_low_q, clk_low_d;
    logic       data_low_q, data_low_d;
    logic       done_q, done_d;
    logic       ack_err_q, ack_err_d;
    logic       timeout_err_q, timeout_err_d;
`ifdef PS2_TX_RETRY_EN
    logic       retry_q, retry_d;
`endif

    logic fall;
    logic dat_sync;
    logic tmo_hit;
    logic fail;
    logic nack;

    assign dat_sync = dat_s_q[1];
    assign tmo_hit  = (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

    // A clock level change is accepted only after FILTER_LEN
    // consecutive samples disagree with the current filtered level.
    always_comb begin
        clk_s_d = {clk_s_q[0], ps2_clk_i};
        dat_s_d = {dat_s_q[0], ps2_data_i};
        filt_d  = filt_q;
        fcnt_d  = '0;
        if (clk_s_q[1] != filt_q) begin
            if (fcnt_q == FLT_W'(FILTER_LEN - 1)) begin
                filt_d = clk_s_q[1];
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end
    end

    assign fall = filt_q & ~filt_d;

    always_comb begin
        state_d       = state_q;
        byte_d        = byte_q;
        bit_d         = bit_q;
        tmr_d         = tmr_q;
        tmo_d         = tmo_q;
        clk_low_d     = clk_low_q;
        data_low_d    = data_low_q;
        done_d        = 1'b0;
        ack_err_d     = 1'b0;
        timeout_err_d = 1'b0;
        fail          = 1'b0;
        nack          = 1'b0;
`ifdef PS2_TX_RETRY_EN
        retry_d       = retry_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (tx_valid && tx_ready) begin
                    byte_d     = tx_data;
                    bit_d      = '0;
                    tmr_d      = '0;
                    clk_low_d  = 1'b1;
                    data_low_d = 1'b0;
                    state_d    = S_INHIBIT;
`ifdef PS2_TX_RETRY_EN
                    retry_d    = 1'b0;
`endif
                end
            end
            S_INHIBIT: begin
                if (tmr_q == TMR_W'(INHIBIT_CYCLES - 1)) begin
                    tmr_d      = '0;
                    data_low_d = 1'b1;
                    state_d    = S_REQ;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            S_REQ: begin
                if (tmr_q == TMR_W'(SETUP_CYCLES - 1)) begin
                    clk_low_d = 1'b0;
                    tmo_d     = '0;
                    state_d   = S_XFER;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            S_XFER: begin
                tmo_d = tmo_q + 1'b1;
                if (tmo_hit) begin
                    fail = 1'b1;
                end else if (fall) begin
                    bit_d = bit_q + 1'b1;
                    if (bit_q < 4'd8) begin
                        data_low_d = ~byte_q[bit_q[2:0]];
                    end else if (bit_q == 4'd8) begin
                        // odd parity bit is ~^byte; pull low when it is 0
                        data_low_d = ^byte_q;
                    end else begin
                        data_low_d = 1'b0;
                        state_d    = S_ACK;
                    end
                end
            end
            S_ACK: begin
                tmo_d = tmo_q + 1'b1;
                if (tmo_hit) begin
                    fail = 1'b1;
                end else if (fall) begin
                    if (!dat_sync) begin
                        state_d = S_WAIT_IDLE;
                    end else begin
                        fail = 1'b1;
                        nack = 1'b1;
                    end
                end
            end
            S_WAIT_IDLE: begin
                tmo_d = tmo_q + 1'b1;
                if (tmo_hit) begin
                    fail = 1'b1;
                end else if (filt_q && dat_sync) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (fail) begin
            clk_low_d  = 1'b0;
            data_low_d = 1'b0;
`ifdef PS2_TX_RETRY_EN
            if (!retry_q) begin
                retry_d   = 1'b1;
                state_d   = S_INHIBIT;
                clk_low_d = 1'b1;
                tmr_d     = '0;
                bit_d     = '0;
            end else begin
                state_d       = S_IDLE;
                ack_err_d     = nack;
                timeout_err_d = ~nack;
            end
`else
            state_d       = S_IDLE;
            ack_err_d     = nack;
            timeout_err_d = ~nack;
`endif
        end
    end

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            state_q       <= S_IDLE;
            byte_q        <= '0;
            bit_q         <= '0;
            tmr_q         <= '0;
            tmo_q         <= '0;
            clk_s_q       <= 2'b11;
            dat_s_q       <= 2'b11;
            filt_q        <= 1'b1;
            fcnt_q        <= '0;
            clk_low_q     <= 1'b0;
            data_low_q    <= 1'b0;
            done_q        <= 1'b0;
            ack_err_q     <= 1'b0;
            timeout_err_q <= 1'b0;
`ifdef PS2_TX_RETRY_EN
            retry_q       <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            byte_q        <= byte_d;
            bit_q         <= bit_d;
            tmr_q         <= tmr_d;
            tmo_q         <= tmo_d;
            clk_s_q       <= clk_s_d;
            dat_s_q       <= dat_s_d;
            filt_q        <= filt_d;
            fcnt_q        <= fcnt_d;
            clk_low_q     <= clk_low_d;
            data_low_q    <= data_low_d;
            done_q        <= done_d;
            ack_err_q     <= ack_err_d;
            timeout_err_q <= timeout_err_d;
`ifdef PS2_TX_RETRY_EN
            retry_q       <= retry_d;
`endif
        end
    end

    // The pulse cycle is already in IDLE; hold off new requests one cycle.
    assign tx_ready     = (state_q == S_IDLE) &
                          ~(done_q | ack_err_q | timeout_err_q);
    assign busy         = ~tx_ready;
    assign done         = done_q;
    assign ack_err      = ack_err_q;
    assign timeout_err  = timeout_err_q;
    assign ps2_clk_low  = clk_low_q;
    assign ps2_data_low = data_low_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: device model on an open-drain bus, frame scoreboard,
// table of command bytes plus reset, timeout and disturbance sequences.
module tb_ps2_host_tx;

    localparam int INH = 20;
    localparam int SET = 5;
    localparam int TMO = 3000;
    localparam int FL  = 8;
    localparam int H   = 40;
`ifdef PS2_TX_RETRY_EN
    localparam int NF = 2;
`else
    localparam int NF = 1;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, busy, done, ack_err, timeout_err;
    logic       ps2_clk_i, ps2_data_i, ps2_clk_low, ps2_data_low;
    logic       dev_clk = 1'b1;
    logic       dev_data = 1'b1;
    logic       glitch = 1'b0;

    assign ps2_clk_i  = dev_clk & ~ps2_clk_low & ~glitch;
    assign ps2_data_i = dev_data & ~ps2_data_low;

    always #5 clk = ~clk;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .SETUP_CYCLES  (SET),
        .TIMEOUT_CYCLES(TMO),
        .FILTER_LEN    (FL)
    ) dut (
        .CLK100MHZ   (clk),
        .CPU_RESETN  (rst_n),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .busy        (busy),
        .done        (done),
        .ack_err     (ack_err),
        .timeout_err (timeout_err),
        .ps2_clk_i   (ps2_clk_i),
        .ps2_data_i  (ps2_data_i),
        .ps2_clk_low (ps2_clk_low),
        .ps2_data_low(ps2_data_low)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // monitor: pulse-cycle counters, inhibit length, release-to-timeout latency
    int   cyc = 0, n_done = 0, n_nack = 0, n_tmo = 0;
    int   inh_run = 0, last_inh = 0, rel_cyc = 0, tmo_lat = 0;
    logic tmo_cl = 1'b1, tmo_dl = 1'b1, prev_cl = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (done) n_done++;
        if (ack_err) n_nack++;
        if (prev_cl && !ps2_clk_low) rel_cyc = cyc;
        if (timeout_err) begin
            n_tmo++;
            tmo_lat = cyc - rel_cyc;
            tmo_cl  = ps2_clk_low;
            tmo_dl  = ps2_data_low;
        end
        if (ps2_clk_low && !ps2_data_low) begin
            inh_run++;
        end else begin
            if (ps2_clk_low && ps2_data_low && inh_run != 0) last_inh = inh_run;
            inh_run = 0;
        end
        prev_cl = ps2_clk_low;
    end

    typedef struct {
        logic [7:0] data;
        logic       ack;
        logic       par;
    } vec_t;

    vec_t       vecs[5];
    logic [10:0] exp_q[$];

    task automatic send(input logic [7:0] b);
        int n;
        n = 0;
        while (!tx_ready && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("send_ready", tx_ready, 1);
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        tx_data  = ~b;
    endtask

    task automatic device_frame(input logic ack, input int stop_after,
                                input bit disturb, output logic [10:0] obs,
                                output bit got);
        int n;
        obs = '0;
        got = 1'b0;
        n = 0;
        while (!(ps2_clk_low === 1'b0 && ps2_data_low === 1'b1) &&
               n < INH + SET + 100) begin
            @(negedge clk);
            n++;
        end
        if (!(ps2_clk_low === 1'b0 && ps2_data_low === 1'b1)) begin
            checks++;
            failures++;
            $display("FAIL req_wait: no request after %0d cycles", n);
            return;
        end
        got = 1'b1;
        repeat (H) @(negedge clk);
        obs[0] = ps2_data_i;
        for (int k = 1; k <= 10; k++) begin
            dev_clk = 1'b0;
            if (stop_after == k) begin
                repeat (H / 2) @(negedge clk);
                return;
            end
            repeat (H / 2) @(negedge clk);
            if (disturb && k == 3) begin
                tx_data  = 8'h55;
                tx_valid = 1'b1;
                chk("ready_in_xfer", tx_ready, 0);
                @(negedge clk);
                @(negedge clk);
                tx_valid = 1'b0;
            end
            repeat (H / 2) @(negedge clk);
            dev_clk = 1'b1;
            repeat (H / 4) @(negedge clk);
            if (disturb) begin
                glitch = 1'b1;
                #20;
                glitch = 1'b0;
                @(negedge clk);
            end
            repeat (H / 4) @(negedge clk);
            obs[k] = ps2_data_i;
            repeat (H / 2) @(negedge clk);
        end
        dev_data = ack;
        repeat (H / 2) @(negedge clk);
        dev_clk = 1'b0;
        repeat (H) @(negedge clk);
        dev_clk = 1'b1;
        repeat (H / 2) @(negedge clk);
        dev_data = 1'b1;
    endtask

    task automatic run_vec(input logic [7:0] d, input logic ack,
                           input logic par, input bit disturb);
        int nf, b_done, b_nack, b_tmo, n;
        logic [10:0] obs, exp;
        bit got;
        nf = ack ? NF : 1;
        b_done = n_done;
        b_nack = n_nack;
        b_tmo  = n_tmo;
        for (int f = 0; f < nf; f++) exp_q.push_back({1'b1, par, d, 1'b0});
        send(d);
        for (int f = 0; f < nf; f++) begin
            device_frame(ack, 0, disturb, obs, got);
            if (got) begin
                exp = exp_q.pop_front();
                chk("frame", {21'd0, obs}, {21'd0, exp});
            end
        end
        n = 0;
        while (n_done + n_nack + n_tmo == b_done + b_nack + b_tmo && n < 500) begin
            @(negedge clk);
            n++;
        end
        repeat (5) @(negedge clk);
        chk("done_cnt", n_done - b_done, ack ? 0 : 1);
        chk("ackerr_cnt", n_nack - b_nack, ack ? 1 : 0);
        chk("tmo_cnt", n_tmo - b_tmo, 0);
        chk("inhibit_len", last_inh, INH);
        chk("lines_idle", {30'd0, ps2_clk_low, ps2_data_low}, 0);
        chk("ready_after", tx_ready, 1);
        chk("sb_empty", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        logic [10:0] obs;
        bit got;
        int b_tmo, b_done, n;

        vecs[0] = '{8'hED, 1'b0, 1'b1};
        vecs[1] = '{8'h07, 1'b0, 1'b0};
        vecs[2] = '{8'h00, 1'b0, 1'b1};
        vecs[3] = '{8'hA5, 1'b1, 1'b1};
        vecs[4] = '{8'h5A, 1'b0, 1'b1};

        repeat (3) @(negedge clk);
        chk("rst_ready", tx_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_pulses", {done, ack_err, timeout_err}, 0);
        chk("rst_lines", {ps2_clk_low, ps2_data_low}, 0);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            run_vec(vecs[i].data, vecs[i].ack, vecs[i].par, 1'b0);
            repeat (20) @(negedge clk);
        end

        // reset mid-frame after fall 4; bit 3 of 0xA0 is 0 so data is held low
        send(8'hA0);
        device_frame(1'b0, 4, 1'b0, obs, got);
        chk("pre_rst_data_low", ps2_data_low, 1);
        #3 rst_n = 1'b0;
        #1;
        chk("async_rst_lines", {ps2_clk_low, ps2_data_low}, 0);
        chk("async_rst_ready", tx_ready, 1);
        dev_clk = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        run_vec(8'hFF, 1'b0, 1'b1, 1'b0);
        repeat (20) @(negedge clk);

        // mid-frame tx_valid and short clock glitches
        run_vec(8'hC3, 1'b0, 1'b1, 1'b1);
        repeat (20) @(negedge clk);

        // silent device: timeout
        b_tmo  = n_tmo;
        b_done = n_done;
        send(8'h12);
        n = 0;
        while (n_tmo == b_tmo && n < NF * (TMO + INH + SET + 100)) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        chk("tmo_pulse", n_tmo - b_tmo, 1);
        chk("tmo_latency", tmo_lat, TMO);
        chk("tmo_lines", {tmo_cl, tmo_dl}, 0);
        chk("tmo_no_done", n_done - b_done, 0);
        chk("tmo_ready", tx_ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
